// File: rtl/tx_scrambler_pacer_pkg.sv
// ============================================================================
// tx_pcs_pkg : shared constants and types for the 10GBASE-R PCS TX path
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_pcs_pkg;

  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [1:0]  SYNC_CTRL  = 2'b10;
  localparam logic [7:0]  BT_IDLE    = 8'h1E;
  // Block type 0x1E followed by eight /I/ characters (7'h00 each)
  localparam logic [63:0] IDLE_BLOCK = {56'h0, BT_IDLE};

  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;
  localparam int SCR_W     = 58;

  localparam logic [5:0] PACE_LAST = 6'd32;

  typedef enum logic [1:0] {
    SLOT_EVEN = 2'd0,
    SLOT_ODD  = 2'd1,
    SLOT_GAP  = 2'd2
  } slot_t;

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] pay;
  } blk_t;

endpackage

`default_nettype wire

// File: rtl/tx_scrambler_pacer_scrambler_32b.sv
// ============================================================================
// scrambler_32b : 32-bit unrolled self-synchronous x^58+x^39+1 scrambler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module scrambler_32b
  import tx_pcs_pkg::*;
#(
  parameter logic [SCR_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bypass,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [SCR_W-1:0] r_state;
  logic [SCR_W-1:0] w_chain;
  logic [31:0]      w_scr;
  logic             w_sb;

  // Bit 0 is transmitted first, so it is shifted through the state first
  always_comb begin
    w_chain = r_state;
    w_scr   = '0;
    w_sb    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_sb     = d[i] ^ w_chain[SCR_TAP_A] ^ w_chain[SCR_TAP_B];
      w_chain  = {w_chain[SCR_W-2:0], w_sb};
      w_scr[i] = w_sb;
    end
  end

  assign q = bypass ? d : w_scr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= SCR_SEED;
    end else if (en && !bypass) begin
      r_state <= w_chain;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_scrambler_pacer.sv
// ============================================================================
// tx_scrambler_pacer : 66b block scrambler and 32/33 pacer feeding TX gearbox
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_scrambler_pacer
  import tx_pcs_pkg::*;
#(
  parameter logic [SCR_W-1:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit               SCR_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic [1:0]  in_hdr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dout,
  output logic [1:0]  ctrl,
  output logic        dout_en,
  output logic        even,
  output logic        idle_ins
);

  logic [5:0]  r_pace_cnt;
  logic [31:0] r_held;
  logic [31:0] r_dout;
  logic [1:0]  r_ctrl;
  logic        r_dout_en;
  logic        r_even;
  logic        r_idle_ins;

  slot_t       w_slot;
  blk_t        w_blk;
  logic [31:0] w_scr_d;
  logic [31:0] w_scr_q;
  logic        w_scr_en;

  logic [5:0]  w_nxt_cnt;
  logic [31:0] w_nxt_held;
  logic [31:0] w_nxt_dout;
  logic [1:0]  w_nxt_ctrl;
  logic        w_nxt_en;
  logic        w_nxt_even;
  logic        w_nxt_idle;

  assign w_slot   = (r_pace_cnt == PACE_LAST) ? SLOT_GAP :
                    (r_pace_cnt[0] ? SLOT_ODD : SLOT_EVEN);
  assign in_ready = rst && (w_slot == SLOT_EVEN);

  // A missing block at an even slot becomes an idle block, never a bubble
  assign w_blk    = in_valid ? blk_t'{hdr: in_hdr, pay: in_data}
                             : blk_t'{hdr: SYNC_CTRL, pay: IDLE_BLOCK};
  assign w_scr_d  = (w_slot == SLOT_EVEN) ? w_blk.pay[31:0] : r_held;
  assign w_scr_en = rst && (w_slot != SLOT_GAP);

  scrambler_32b #(
    .SCR_SEED (SCR_SEED)
  ) u_scr (
    .clk    (clk),
    .rst    (rst),
    .en     (w_scr_en),
    .bypass (SCR_BYPASS),
    .d      (w_scr_d),
    .q      (w_scr_q)
  );

  always_comb begin
    w_nxt_cnt  = (r_pace_cnt == PACE_LAST) ? 6'd0 : r_pace_cnt + 6'd1;
    w_nxt_held = r_held;
    w_nxt_dout = r_dout;
    w_nxt_ctrl = 2'b00;
    w_nxt_en   = 1'b0;
    w_nxt_even = 1'b0;
    w_nxt_idle = 1'b0;
    case (w_slot)
      SLOT_EVEN: begin
        w_nxt_dout = w_scr_q;
        w_nxt_ctrl = w_blk.hdr;
        w_nxt_en   = 1'b1;
        w_nxt_even = 1'b1;
        w_nxt_idle = !in_valid;
        w_nxt_held = w_blk.pay[63:32];
      end
      SLOT_ODD: begin
        w_nxt_dout = w_scr_q;
        w_nxt_en   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pace_cnt <= 6'd0;
      r_held     <= 32'd0;
      r_dout     <= 32'd0;
      r_ctrl     <= 2'b00;
      r_dout_en  <= 1'b0;
      r_even     <= 1'b0;
      r_idle_ins <= 1'b0;
    end else begin
      r_pace_cnt <= w_nxt_cnt;
      r_held     <= w_nxt_held;
      r_dout     <= w_nxt_dout;
      r_ctrl     <= w_nxt_ctrl;
      r_dout_en  <= w_nxt_en;
      r_even     <= w_nxt_even;
      r_idle_ins <= w_nxt_idle;
    end
  end

  assign dout     = r_dout;
  assign ctrl     = r_ctrl;
  assign dout_en  = r_dout_en;
  assign even     = r_even;
  assign idle_ins = r_idle_ins;

endmodule

`default_nettype wire

// File: tb/tb_tx_scrambler_pacer.sv
// ============================================================================
// tb_tx_scrambler_pacer : randomized bench with a block-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_scrambler_pacer;
  import tx_pcs_pkg::*;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_hdr = '0;
  logic        in_valid = 1'b0;

  logic        in_ready, dout_en, even, idle_ins;
  logic [31:0] dout;
  logic [1:0]  ctrl;
  logic        b_in_ready, b_dout_en, b_even, b_idle_ins;
  logic [31:0] b_dout;
  logic [1:0]  b_ctrl;

  always #5 clk = ~clk;

  tx_scrambler_pacer #(.SCR_SEED(SEED), .SCR_BYPASS(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .ctrl(ctrl),
    .dout_en(dout_en), .even(even), .idle_ins(idle_ins)
  );

  tx_scrambler_pacer #(.SCR_SEED(SEED), .SCR_BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hdr(in_hdr),
    .in_valid(in_valid), .in_ready(b_in_ready), .dout(b_dout), .ctrl(b_ctrl),
    .dout_en(b_dout_en), .even(b_even), .idle_ins(b_idle_ins)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: position within the 33-cycle period, scrambler and
  // descrambler state, held high half and expected registered outputs.
  int          m_k = 0;
  logic [57:0] m_s = SEED;
  logic [57:0] m_d = SEED;
  logic [31:0] m_held = '0;
  logic [31:0] e_dout = '0, e_bdout = '0, e_plain = '0;
  logic [1:0]  e_ctrl = '0;
  logic        e_en = 0, e_even = 0, e_idle = 0;
  int          n_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic scr_step(input logic [31:0] d, output logic [31:0] o);
    logic sb;
    for (int i = 0; i < 32; i++) begin
      sb   = d[i] ^ m_s[38] ^ m_s[57];
      m_s  = {m_s[56:0], sb};
      o[i] = sb;
    end
  endtask

  task automatic dscr_step(input logic [31:0] r, output logic [31:0] o);
    for (int i = 0; i < 32; i++) begin
      o[i] = r[i] ^ m_d[38] ^ m_d[57];
      m_d  = {m_d[56:0], r[i]};
    end
  endtask

  task automatic model_step();
    logic [65:0] blk;
    logic [31:0] o;
    if (!rst) begin
      m_k = 0; m_s = SEED; m_d = SEED; m_held = '0;
      e_dout = '0; e_bdout = '0; e_ctrl = '0; e_en = 0; e_even = 0; e_idle = 0;
    end else if (m_k < 32 && m_k % 2 == 0) begin
      blk = in_valid ? {in_hdr, in_data} : {SYNC_CTRL, IDLE_BLOCK};
      scr_step(blk[31:0], o);
      e_dout = o; e_bdout = blk[31:0]; e_plain = blk[31:0];
      e_ctrl = blk[65:64]; e_en = 1; e_even = 1; e_idle = !in_valid;
      m_held = blk[63:32];
      m_k++;
    end else if (m_k < 32) begin
      scr_step(m_held, o);
      e_dout = o; e_bdout = m_held; e_plain = m_held;
      e_ctrl = 2'b00; e_en = 1; e_even = 0; e_idle = 0;
      m_k++;
    end else begin
      e_ctrl = 2'b00; e_en = 0; e_even = 0; e_idle = 0;
      m_k = 0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] p;
    chk("dout", dout, e_dout);
    chk("ctrl", ctrl, e_ctrl);
    chk("dout_en", dout_en, e_en);
    chk("even", even, e_even);
    chk("idle_ins", idle_ins, e_idle);
    chk("byp_dout", b_dout, e_bdout);
    chk("byp_ctrl", b_ctrl, e_ctrl);
    chk("byp_en", b_dout_en, e_en);
    if (e_en) begin
      dscr_step(dout, p);
      chk("descrambled", p, e_plain);
    end
  endtask

  // One clock: drive inputs at the falling edge, check the result one edge later
  task automatic cyc(input logic r, input logic v, input logic [1:0] h, input logic [63:0] d);
    rst = r; in_valid = v; in_hdr = h; in_data = d;
    #1;
    chk("in_ready", in_ready, (r && m_k < 32 && m_k % 2 == 0));
    chk("byp_ready", b_in_ready, (r && m_k < 32 && m_k % 2 == 0));
    if (in_ready && in_valid) n_acc++;
    model_step();
    @(negedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [1:0] rnd_hdr();
    int x = $urandom_range(0, 9);
    if (x <= 5) return SYNC_DATA;
    if (x <= 8) return SYNC_CTRL;
    return 2'($urandom);
  endfunction

  task automatic rnd_cyc(input int pct_valid);
    cyc(1'b1, ($urandom_range(0, 99) < pct_valid), rnd_hdr(), {$urandom, $urandom});
  endtask

  initial begin
    int cnt, lows, guard;
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b1, SYNC_DATA, '0);

    // Counting stream, always valid
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b1, SYNC_DATA, {32'(2*i+1), 32'(2*i)});

    // Random traffic with stalls and occasional invalid headers
    for (int i = 0; i < 250; i++) rnd_cyc(75);

    // Encoder silent: idle blocks only
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      cyc(1'b1, 1'b0, '0, '0);
      if (i >= 5 && i < 38) cnt += int'(idle_ins);
    end
    chk("idle_per_33", 32'(cnt), 32'd16);

    // All-zero data payload: raw scrambler sequence; acceptance/gap counts
    n_acc = 0; lows = 0;
    for (int i = 0; i < 33; i++) begin
      cyc(1'b1, 1'b1, SYNC_DATA, '0);
      lows += int'(!dout_en);
    end
    chk("acc_per_33", 32'(n_acc), 32'd16);
    chk("gaps_per_33", 32'(lows), 32'd1);

    // Single stall mid-stream
    for (int i = 0; i < 20; i++) rnd_cyc(100);
    guard = 0;
    while (!(m_k < 32 && m_k % 2 == 0) && guard < 40) begin rnd_cyc(100); guard++; end
    cyc(1'b1, 1'b0, '0, '0);
    chk("one_idle", idle_ins, 1'b1);
    for (int i = 0; i < 20; i++) rnd_cyc(100);

    // Reset asserted on an odd slot, held for three cycles
    guard = 0;
    while (!(m_k < 32 && m_k % 2 == 1) && guard < 40) begin rnd_cyc(80); guard++; end
    chk("odd_slot_found", 32'(guard < 40), 32'd1);
    repeat (3) cyc(1'b0, 1'b1, rnd_hdr(), {$urandom, $urandom});
    cyc(1'b1, 1'b1, SYNC_DATA, {$urandom, $urandom});
    chk("first_after_rst_en", dout_en, 1'b1);
    chk("first_after_rst_even", even, 1'b1);

    for (int i = 0; i < 300; i++) rnd_cyc(85);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
